// File: rtl/cycle_timer_if.sv
// Load handshake, control and status bundle for cycle_timer.
// TIMER_AUTO_RELOAD_EN adds the reload_en control signal.
interface cycle_timer_if #(
    parameter int WIDTH = 28
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_cycles;
    logic             pause;
    logic             abort;
`ifdef TIMER_AUTO_RELOAD_EN
    logic             reload_en;
`endif
    logic             tmr_start;
    logic             tmr_end;
    logic             aborted;
    logic             load_err;
    logic             busy;
    logic [WIDTH-1:0] remain;

    // Sequencer / software side
    modport master (
        output load_valid, load_cycles, pause, abort,
`ifdef TIMER_AUTO_RELOAD_EN
        output reload_en,
`endif
        input  load_ready, tmr_start, tmr_end, aborted, load_err, busy, remain
    );

    // Timer side
    modport slave (
        input  load_valid, load_cycles, pause, abort,
`ifdef TIMER_AUTO_RELOAD_EN
        input  reload_en,
`endif
        output load_ready, tmr_start, tmr_end, aborted, load_err, busy, remain
    );
endinterface

// File: rtl/cycle_timer.sv
// One-shot interval timer: a load of N emits tmr_start, counts N unpaused cycles, then emits tmr_end.
// Define TIMER_AUTO_RELOAD_EN to add periodic auto-reload through reload_en.
module cycle_timer #(
    parameter int WIDTH = 28
) (
    input  logic          clk,
    input  logic          resetn,
    cycle_timer_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remain_q, remain_d;
    logic             start_q, start_d;
    logic             end_q, end_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;
    logic             load_fire;
    logic             reload_now;

`ifdef TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] period_q, period_d;
`endif

    assign load_fire = bus.load_valid && (state_q == IDLE);

`ifdef TIMER_AUTO_RELOAD_EN
    assign reload_now = bus.reload_en;
`else
    assign reload_now = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        start_d   = 1'b0;
        end_d     = 1'b0;
        aborted_d = 1'b0;
        err_d     = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        period_d  = period_q;
`endif

        unique case (state_q)
            IDLE: begin
                // abort and pause have no meaning here; only a load moves the FSM
                if (load_fire) begin
`ifdef TIMER_AUTO_RELOAD_EN
                    period_d = bus.load_cycles;
`endif
                    if (bus.load_cycles == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        remain_d = bus.load_cycles;
                        start_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    remain_d  = '0;
                    end_d     = 1'b1;
                    aborted_d = 1'b1;
                end else if (!bus.pause) begin
                    if (remain_q > WIDTH'(1)) begin
                        remain_d = remain_q - WIDTH'(1);
                    end else begin
                        end_d = 1'b1;
                        if (reload_now) begin
`ifdef TIMER_AUTO_RELOAD_EN
                            remain_d = period_q;
`endif
                            start_d  = 1'b1;
                        end else begin
                            remain_d = '0;
                            state_d  = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                remain_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            start_q   <= start_d;
            end_q     <= end_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

`ifdef TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end
`endif

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q == RUN);
    assign bus.remain     = remain_q;
    assign bus.tmr_start  = start_q;
    assign bus.tmr_end    = end_q;
    assign bus.aborted    = aborted_q;
    assign bus.load_err   = err_q;

endmodule

// File: tb/tb_cycle_timer.sv
// Directed self-checking bench for cycle_timer; outputs are sampled 1 time unit after each rising edge.
// Auto-reload steps run only when TIMER_AUTO_RELOAD_EN is defined.
module tb_cycle_timer;

    localparam int WIDTH = 28;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    cycle_timer_if #(.WIDTH(WIDTH)) bus ();

    cycle_timer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, ".ready"}, {31'd0, bus.load_ready}, 32'd1);
        check({tag, ".remain"}, {4'd0, bus.remain}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_valid  = 1'b0;
        bus.load_cycles = '0;
        bus.pause       = 1'b0;
        bus.abort       = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        bus.reload_en   = 1'b0;
`endif

        // Reset state
        #12;
        check("rst.start", {31'd0, bus.tmr_start}, 32'd0);
        check("rst.end", {31'd0, bus.tmr_end}, 32'd0);
        check("rst.aborted", {31'd0, bus.aborted}, 32'd0);
        check("rst.err", {31'd0, bus.load_err}, 32'd0);
        check_idle("rst");
        resetn = 1'b1;
        tick();

        // N=5 basic interval
        bus.load_valid = 1'b1; bus.load_cycles = 28'd5;
        tick();
        bus.load_valid = 1'b0;
        check("n5.start", {31'd0, bus.tmr_start}, 32'd1);
        check("n5.busy", {31'd0, bus.busy}, 32'd1);
        check("n5.ready", {31'd0, bus.load_ready}, 32'd0);
        check("n5.rem1", {4'd0, bus.remain}, 32'd5);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("n5.rem", {4'd0, bus.remain}, 32'(6 - k));
            check("n5.nostart", {31'd0, bus.tmr_start}, 32'd0);
            check("n5.noend", {31'd0, bus.tmr_end}, 32'd0);
        end
        tick();
        check("n5.end", {31'd0, bus.tmr_end}, 32'd1);
        check("n5.end_aborted", {31'd0, bus.aborted}, 32'd0);
        check_idle("n5.done");
        tick();
        check("n5.end_once", {31'd0, bus.tmr_end}, 32'd0);

        // N=1 shortest interval
        bus.load_valid = 1'b1; bus.load_cycles = 28'd1;
        tick();
        bus.load_valid = 1'b0;
        check("n1.start", {31'd0, bus.tmr_start}, 32'd1);
        check("n1.rem", {4'd0, bus.remain}, 32'd1);
        check("n1.noend", {31'd0, bus.tmr_end}, 32'd0);
        tick();
        check("n1.end", {31'd0, bus.tmr_end}, 32'd1);
        check("n1.nostart", {31'd0, bus.tmr_start}, 32'd0);
        check_idle("n1.done");

        // N=0 rejected load
        bus.load_valid = 1'b1; bus.load_cycles = 28'd0;
        tick();
        bus.load_valid = 1'b0;
        check("n0.err", {31'd0, bus.load_err}, 32'd1);
        check("n0.nostart", {31'd0, bus.tmr_start}, 32'd0);
        check_idle("n0");
        tick();
        check("n0.err_once", {31'd0, bus.load_err}, 32'd0);
        check("n0.still_idle", {31'd0, bus.busy}, 32'd0);

        // N=4 with pause high during T+2..T+4: remain holds at 3, tmr_end at T+8
        bus.load_valid = 1'b1; bus.load_cycles = 28'd4;
        tick();
        bus.load_valid = 1'b0;
        check("pz.rem_t1", {4'd0, bus.remain}, 32'd4);
        tick();
        bus.pause = 1'b1;
        check("pz.rem_t2", {4'd0, bus.remain}, 32'd3);
        tick();
        check("pz.rem_t3", {4'd0, bus.remain}, 32'd3);
        tick();
        check("pz.rem_t4", {4'd0, bus.remain}, 32'd3);
        tick();
        bus.pause = 1'b0;
        check("pz.rem_t5", {4'd0, bus.remain}, 32'd3);
        tick();
        check("pz.rem_t6", {4'd0, bus.remain}, 32'd2);
        tick();
        check("pz.rem_t7", {4'd0, bus.remain}, 32'd1);
        check("pz.noend_t7", {31'd0, bus.tmr_end}, 32'd0);
        tick();
        check("pz.end_t8", {31'd0, bus.tmr_end}, 32'd1);
        check_idle("pz.done");

        // N=10, abort in T+4
        bus.load_valid = 1'b1; bus.load_cycles = 28'd10;
        tick();
        bus.load_valid = 1'b0;
        tick(); tick(); tick();
        check("ab.rem_t4", {4'd0, bus.remain}, 32'd7);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab.end", {31'd0, bus.tmr_end}, 32'd1);
        check("ab.aborted", {31'd0, bus.aborted}, 32'd1);
        check_idle("ab.done");
        tick();
        check("ab.end_once", {31'd0, bus.tmr_end}, 32'd0);
        check("ab.aborted_once", {31'd0, bus.aborted}, 32'd0);

        // Abort coincident with remain==1, with pause also high: one tmr_end, aborted set
        bus.load_valid = 1'b1; bus.load_cycles = 28'd2;
        tick();
        bus.load_valid = 1'b0;
        tick();
        check("abt.rem1", {4'd0, bus.remain}, 32'd1);
        bus.abort = 1'b1; bus.pause = 1'b1;
        tick();
        bus.abort = 1'b0; bus.pause = 1'b0;
        check("abt.end", {31'd0, bus.tmr_end}, 32'd1);
        check("abt.aborted", {31'd0, bus.aborted}, 32'd1);
        check_idle("abt.done");
        tick();
        check("abt.single_end", {31'd0, bus.tmr_end}, 32'd0);

        // Abort in IDLE does not block a simultaneous load
        bus.abort = 1'b1; bus.load_valid = 1'b1; bus.load_cycles = 28'd2;
        tick();
        bus.abort = 1'b0; bus.load_valid = 1'b0;
        check("ai.start", {31'd0, bus.tmr_start}, 32'd1);
        check("ai.busy", {31'd0, bus.busy}, 32'd1);
        check("ai.rem", {4'd0, bus.remain}, 32'd2);
        tick(); tick();
        check("ai.end", {31'd0, bus.tmr_end}, 32'd1);
        check("ai.not_aborted", {31'd0, bus.aborted}, 32'd0);

        // load_valid held with N=3: starts at T+1, T+5, T+9; ready only at T+4k
        bus.load_valid = 1'b1; bus.load_cycles = 28'd3;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 12) bus.load_valid = 1'b0;
            check("b2b.start", {31'd0, bus.tmr_start}, 32'((k % 4) == 1));
            check("b2b.end", {31'd0, bus.tmr_end}, 32'((k % 4) == 0));
            check("b2b.ready", {31'd0, bus.load_ready}, 32'((k % 4) == 0));
        end
        tick();
        check_idle("b2b.done");

        // Reset mid-RUN: outputs clear immediately, no tmr_end afterwards
        bus.load_valid = 1'b1; bus.load_cycles = 28'd5;
        tick();
        bus.load_valid = 1'b0;
        tick();
        check("mr.busy_before", {31'd0, bus.busy}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("mr.start", {31'd0, bus.tmr_start}, 32'd0);
        check("mr.end", {31'd0, bus.tmr_end}, 32'd0);
        check_idle("mr");
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("mr.no_end", {31'd0, bus.tmr_end}, 32'd0);
            check("mr.no_busy", {31'd0, bus.busy}, 32'd0);
        end

`ifdef TIMER_AUTO_RELOAD_EN
        // Auto-reload N=3: start T+1, start+end T+4/7/10; reload_en dropped -> IDLE at T+13
        bus.reload_en = 1'b1;
        bus.load_valid = 1'b1; bus.load_cycles = 28'd3;
        for (int k = 1; k <= 13; k++) begin
            tick();
            bus.load_valid = 1'b0;
            check("ar.start", {31'd0, bus.tmr_start}, 32'(k == 1 || k == 4 || k == 7 || k == 10));
            check("ar.end", {31'd0, bus.tmr_end}, 32'(k == 4 || k == 7 || k == 10 || k == 13));
            check("ar.busy", {31'd0, bus.busy}, 32'(k < 13));
            check("ar.rem", {4'd0, bus.remain}, (k == 13) ? 32'd0 : 32'(3 - ((k - 1) % 3)));
            if (k == 10) bus.reload_en = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cycle_timer.md
Name: cycle_timer

Overview:
- Interval generator that drives the start/end pulse pair of a cycle-measurement interface.
- Software or a sequencer loads a cycle count through a valid/ready handshake.
- The block emits a one-cycle tmr_start pulse, counts down the programmed number of non-paused cycles, then emits a one-cycle tmr_end pulse.
- Sits upstream of the cycle counters in the perf/timing subsystem; also serves as a generic one-shot timer.

Parameters:
WIDTH  28  width of load_cycles and remain; max interval 2^WIDTH-1 cycles

Ports:
clk          input   1      clock, rising edge
resetn       input   1      asynchronous, active-low reset
load_valid   input   1      load request
load_ready   output  1      block can accept load (combinational, = state IDLE)
load_cycles  input   WIDTH  interval length N in cycles, sampled on handshake
pause        input   1      freeze countdown while high (RUN only)
abort        input   1      terminate running interval
tmr_start    output  1      one-cycle pulse, interval begins
tmr_end      output  1      one-cycle pulse, interval ends (normal or abort)
aborted      output  1      one-cycle pulse, coincident with tmr_end on abort
load_err     output  1      one-cycle pulse, zero-length load rejected
busy         output  1      high while in RUN
remain       output  WIDTH  cycles left in current interval

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk. State IDLE, remain=0. tmr_start, tmr_end, aborted, load_err, busy all 0. load_ready=1. Reset mid-RUN aborts silently: no tmr_end is emitted.
- States: IDLE and RUN. All outputs except load_ready are registered.
- Handshake: a load is accepted in cycle T when load_valid & load_ready. load_valid while busy is held off (load_ready=0) and is not lost.
- Load with N != 0:
  - Cycle T+1: tmr_start=1, busy=1, remain=N, state RUN.
- RUN, each rising edge with pause=0 and abort=0:
  - remain>1: remain <= remain-1.
  - remain==1: remain <= 0, tmr_end <= 1, state <= IDLE.
- Timing with no pause: remain = N at T+1 … 1 at T+N. tmr_end is high in T+N+1. busy is high T+1..T+N and low in T+N+1. The start-to-end pulse spacing is exactly N cycles.
- Back-to-back: load_ready=1 in T+N+1. A load accepted there gives the next tmr_start in T+N+2.
- Pause: while pause=1 in RUN, remain holds. Each paused cycle delays tmr_end by one cycle. pause is ignored in IDLE.
- Abort in RUN:
  - Next cycle: tmr_end=1, aborted=1, remain=0, state IDLE.
  - abort takes priority over pause and over natural terminal count. If abort and remain==1 coincide, only one tmr_end is emitted, with aborted=1.
  - abort in IDLE is ignored. It does not block a simultaneous load.
- Load with N == 0: accepted (consumes the handshake). Next cycle load_err=1. No tmr_start, state stays IDLE.
- No pulse ever lasts more than one cycle.
- tmr_start and tmr_end are never high in the same cycle, except in auto-reload mode (see Optional Feature).
- Arithmetic: unsigned decrement only. remain never wraps below 0.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- When defined:
  - Extra input reload_en (1 bit) and an internal period register.
  - The period register captures load_cycles on each accepted load.
  - At natural terminal count with reload_en=1: tmr_end=1 and tmr_start=1 in the same cycle, remain=period, state stays RUN, busy stays 1.
  - This gives a continuous periodic interval of exactly N cycles.
  - reload_en=0 at terminal count behaves as one-shot.
  - abort always ends in IDLE regardless of reload_en.
- When undefined: reload_en port and period register are absent; the block is strictly one-shot.

Test Plan:
- Reset, then load N=5 at T -> tmr_start in T+1, remain 5,4,3,2,1 over T+1..T+5, tmr_end in T+6, busy low T+6, load_ready high T+6.
- Load N=1 -> tmr_start at T+1, tmr_end at T+2. Load N=0 -> load_err at T+1, no tmr_start, busy stays 0.
- Load N=4, pause high 3 cycles starting T+2 -> remain holds at 3 during the pause, tmr_end at T+8.
- Load N=10, abort at T+4 -> tmr_end and aborted high at T+5, remain 0. Separately, abort coincident with remain==1 -> exactly one tmr_end with aborted=1.
- load_valid held high with N=3 continuously -> starts at T+1, T+5, T+9; load_ready low during busy. Drop resetn mid-RUN -> all outputs 0 immediately, no tmr_end.
- With TIMER_AUTO_RELOAD_EN and reload_en=1, N=3 -> tmr_start at T+1, then coincident tmr_start/tmr_end at T+4, T+7, T+10. Deassert reload_en -> next terminal count goes to IDLE.
